// File: rtl/miriscv_mult_pkg.sv
// Shared types and constants for the iterative MDU multiplier.
package miriscv_mult_pkg;

  localparam int unsigned MULT_W     = 33;
  localparam int unsigned MULT_RES_W = 64;

  typedef enum logic [1:0] {
    MULT_IDLE,
    MULT_CALC,
    MULT_FIX,
    MULT_DONE
  } mult_state_e;

  // CALC cycles needed to retire all 32 magnitude bits at bpc bits per cycle.
  function automatic int unsigned mult_iter(input int unsigned bpc);
    return 32 / bpc;
  endfunction

endpackage

// File: rtl/miriscv_mult_iter_if.sv
// MDU <-> multiplier request/response bundle.
interface miriscv_mult_iter_if;
  import miriscv_mult_pkg::*;

  logic                  req_i;
  logic [MULT_W-1:0]     a_i;
  logic [MULT_W-1:0]     b_i;
  logic                  zero_i;
  logic                  kill_i;
  logic [MULT_RES_W-1:0] result_o;
  logic                  rdy_o;

  modport master (
    output req_i, a_i, b_i, zero_i, kill_i,
    input  result_o, rdy_o
  );

  modport slave (
    input  req_i, a_i, b_i, zero_i, kill_i,
    output result_o, rdy_o
  );

endinterface

// File: rtl/miriscv_mult_step.sv
// One shift-and-add step: folds BPC multiplier bits into the 64-bit accumulator.
module miriscv_mult_step
  import miriscv_mult_pkg::*;
#(
  parameter int unsigned BPC = 2
) (
  input  logic [MULT_RES_W-1:0] acc_i,
  input  logic [31:0]           mag_a_i,
  input  logic [BPC-1:0]        chunk_i,
  input  logic [5:0]            shift_i,
  output logic [MULT_RES_W-1:0] acc_o
);

  logic [MULT_RES_W-1:0] partial;

  always_comb begin
    partial = MULT_RES_W'(mag_a_i) * MULT_RES_W'(chunk_i);
    acc_o   = acc_i + (partial << shift_i);
  end

endmodule

// File: rtl/miriscv_mult_iter.sv
// Iterative signed 33x33 multiplier: unsigned magnitude product over 32/BPC
// cycles, sign fix-up, then a one-cycle result strobe. Zero operands bypass.
module miriscv_mult_iter
  import miriscv_mult_pkg::*;
#(
  parameter int unsigned BPC = 2
) (
  input logic                 clk_i,
  input logic                 arstn_i,
  miriscv_mult_iter_if.slave  bus
);

  localparam int unsigned ITER = mult_iter(BPC);
  localparam int unsigned CntW = 5;

  mult_state_e           state_q, state_d;
  logic [31:0]           mag_a_q, mag_a_d;
  logic [31:0]           mag_b_q, mag_b_d;
  logic                  neg_q, neg_d;
  logic [MULT_RES_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [MULT_RES_W-1:0] res_q, res_d;

  logic [31:0]           mag_a_in, mag_b_in;
  logic [MULT_RES_W-1:0] acc_step;
  logic [5:0]            shift;
  logic                  abort;
  logic                  rdy;
  logic [MULT_RES_W-1:0] result;

  // Legal operands never reach -2^32, so the low 32 bits of |x| are exact.
  assign mag_a_in = bus.a_i[MULT_W-1] ? (~bus.a_i[31:0] + 32'd1) : bus.a_i[31:0];
  assign mag_b_in = bus.b_i[MULT_W-1] ? (~bus.b_i[31:0] + 32'd1) : bus.b_i[31:0];
  assign shift    = 6'(cnt_q * BPC);
  assign abort    = bus.kill_i | ~bus.req_i;

  miriscv_mult_step #(
    .BPC (BPC)
  ) u_step (
    .acc_i   (acc_q),
    .mag_a_i (mag_a_q),
    .chunk_i (mag_b_q[BPC-1:0]),
    .shift_i (shift),
    .acc_o   (acc_step)
  );

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rdy     = 1'b0;
    result  = res_q;

    case (state_q)
      MULT_IDLE: begin
        if (bus.req_i && !bus.kill_i) begin
          if (bus.zero_i) begin
            rdy    = 1'b1;
            result = '0;
            res_d  = '0;
          end else begin
            mag_a_d = mag_a_in;
            mag_b_d = mag_b_in;
            neg_d   = bus.a_i[MULT_W-1] ^ bus.b_i[MULT_W-1];
            acc_d   = '0;
            cnt_d   = '0;
            state_d = MULT_CALC;
          end
        end
      end
      MULT_CALC: begin
        if (abort) begin
          state_d = MULT_IDLE;
        end else begin
          acc_d   = acc_step;
          mag_b_d = mag_b_q >> BPC;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntW'(ITER - 1)) begin
            state_d = MULT_FIX;
          end
        end
      end
      MULT_FIX: begin
        if (abort) begin
          state_d = MULT_IDLE;
        end else begin
          res_d   = neg_q ? (~acc_q + 64'd1) : acc_q;
          state_d = MULT_DONE;
        end
      end
      MULT_DONE: begin
        state_d = MULT_IDLE;
        rdy     = ~abort;
      end
      default: begin
        state_d = MULT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= MULT_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign bus.rdy_o    = rdy;
  assign bus.result_o = result;

endmodule
